// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a command rectangle to the 256x192 RGB332 framebuffer and
// streams one VRAM byte write per pixel in raster order, honouring write backpressure.
module rect_fill_engine #(
    parameter int H_SRC  = 256,
    parameter int V_SRC  = 192,
    parameter int ADDR_W = 17
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x0,
    input  logic [7:0]        cmd_y0,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    output logic              vram_we,
    input  logic              vram_wready,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [7:0]        vram_wdata,
    output logic              busy,
    output logic              done
);
    localparam logic [8:0] X_LIMIT = 9'(H_SRC);
    localparam logic [8:0] Y_LIMIT = 9'(V_SRC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLIP,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          x0_reg, x0_next;
    logic [7:0]          y0_reg, y0_next;
    logic [8:0]          w_reg, w_next;
    logic [7:0]          h_reg, h_next;
    logic [7:0]          color_reg, color_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [8:0]          x_end_reg, x_end_next;
    logic [8:0]          y_end_reg, y_end_next;
    logic [7:0]          cx_reg, cx_next;
    logic [7:0]          cy_reg, cy_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic                vram_we_reg, vram_we_next;
    logic [ADDR_W-1:0]   vram_waddr_reg, vram_waddr_next;
    logic [7:0]          vram_wdata_reg, vram_wdata_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    // Sums are 9 bits wide so that x0+w and y0+h never wrap before clipping.
    logic [8:0] x_sum;
    logic [8:0] y_sum;
    logic       clip_empty;
    logic       x_last;
    logic       y_last;

    assign x_sum      = {1'b0, x0_reg} + w_reg;
    assign y_sum      = {1'b0, y0_reg} + {1'b0, h_reg};
    assign clip_empty = (w_reg == 9'd0) || (h_reg == 8'd0) || ({1'b0, y0_reg} >= Y_LIMIT);
    assign x_last     = (({1'b0, cx_reg} + 9'd1) == x_end_reg);
    assign y_last     = (({1'b0, cy_reg} + 9'd1) == y_end_reg);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            x0_reg         <= '0;
            y0_reg         <= '0;
            w_reg          <= '0;
            h_reg          <= '0;
            color_reg      <= '0;
            base_reg       <= '0;
            x_end_reg      <= '0;
            y_end_reg      <= '0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            cmd_ready_reg  <= 1'b1;
            vram_we_reg    <= 1'b0;
            vram_waddr_reg <= '0;
            vram_wdata_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x0_reg         <= x0_next;
            y0_reg         <= y0_next;
            w_reg          <= w_next;
            h_reg          <= h_next;
            color_reg      <= color_next;
            base_reg       <= base_next;
            x_end_reg      <= x_end_next;
            y_end_reg      <= y_end_next;
            cx_reg         <= cx_next;
            cy_reg         <= cy_next;
            cmd_ready_reg  <= cmd_ready_next;
            vram_we_reg    <= vram_we_next;
            vram_waddr_reg <= vram_waddr_next;
            vram_wdata_reg <= vram_wdata_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        x0_next         = x0_reg;
        y0_next         = y0_reg;
        w_next          = w_reg;
        h_next          = h_reg;
        color_next      = color_reg;
        base_next       = base_reg;
        x_end_next      = x_end_reg;
        y_end_next      = y_end_reg;
        cx_next         = cx_reg;
        cy_next         = cy_reg;
        cmd_ready_next  = cmd_ready_reg;
        vram_we_next    = vram_we_reg;
        vram_waddr_next = vram_waddr_reg;
        vram_wdata_next = vram_wdata_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    x0_next        = cmd_x0;
                    y0_next        = cmd_y0;
                    w_next         = cmd_w;
                    h_next         = cmd_h;
                    color_next     = cmd_color;
                    base_next      = BASE_ADDR;
                    cmd_ready_next = 1'b0;
                    busy_next      = 1'b1;
                    state_next     = ST_CLIP;
                end
            end
            ST_CLIP: begin
                x_end_next = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
                y_end_next = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
                if (clip_empty) begin
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cx_next         = x0_reg;
                    cy_next         = y0_reg;
                    vram_we_next    = 1'b1;
                    vram_wdata_next = color_reg;
                    state_next      = ST_FILL;
                end
            end
            ST_FILL: begin
                // Nothing advances until the arbiter takes the current write.
                if (vram_wready) begin
                    if (!x_last) begin
                        cx_next = cx_reg + 8'd1;
                    end else if (!y_last) begin
                        cx_next = x0_reg;
                        cy_next = cy_reg + 8'd1;
                    end else begin
                        vram_we_next = 1'b0;
                        done_next    = 1'b1;
                        state_next   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_next      = 1'b0;
                busy_next      = 1'b0;
                cmd_ready_next = 1'b1;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Address follows the next pixel position; wraps modulo 2^ADDR_W.
        if (state_next == ST_FILL)
            vram_waddr_next = base_reg + ADDR_W'({cy_next, 8'h00}) + ADDR_W'(cx_next);
    end

    assign cmd_ready  = cmd_ready_reg;
    assign vram_we    = vram_we_reg;
    assign vram_waddr = vram_waddr_reg;
    assign vram_wdata = vram_wdata_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed scenarios plus randomized commands
// compared against a clip-by-filtering pixel model.
module tb_rect_fill_engine;
    localparam int ADDR_W = 17;

    logic              clk25 = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_x0;
    logic [7:0]        cmd_y0;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [7:0]        cmd_color;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic              vram_we;
    logic              vram_wready;
    logic [ADDR_W-1:0] vram_waddr;
    logic [7:0]        vram_wdata;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [16:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    int          obs_cyc[$];
    int          exp_addr[$];

    int   done_cyc, we_cycles, hold_err, ready_busy_err;
    logic c1_busy, c1_we, ready_after, busy_after, done_after;
    bit   timed_out;

    rect_fill_engine #(.H_SRC(256), .V_SRC(192), .ADDR_W(ADDR_W)) dut (
        .clk25(clk25), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .BASE_ADDR(BASE_ADDR),
        .vram_we(vram_we), .vram_wready(vram_wready),
        .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk25 = ~clk25;

    // Reference: every pixel of the unclipped rectangle, kept only if it lies on screen.
    task automatic build_model(input int x0, input int y0, input int w, input int h, input int base);
        exp_addr.delete();
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                if (x < 256 && y < 192)
                    exp_addr.push_back((base + y * 256 + x) % 131072);
    endtask

    function automatic int first_bad(input logic [7:0] col);
        if (obs_addr.size() != exp_addr.size()) return -2;
        foreach (obs_addr[i])
            if (obs_addr[i] !== 17'(exp_addr[i]) || obs_data[i] !== col) return i;
        return -1;
    endfunction

    // Issues one command (cycle 0 = accept cycle) and records writes until the cycle after done.
    task automatic run_cmd(input logic [7:0] x0, input logic [7:0] y0, input logic [8:0] w,
                           input logic [7:0] h, input logic [7:0] col, input logic [16:0] base,
                           input int bp_mode, input bit spam, input int max_cyc);
        int          cyc;
        logic        prev_stall;
        logic [16:0] prev_addr;
        logic [7:0]  prev_data;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        done_cyc = -1; we_cycles = 0; hold_err = 0; ready_busy_err = 0; timed_out = 0;
        cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = col; BASE_ADDR = base;
        cmd_valid = 1'b1;
        @(posedge clk25); #1;
        cmd_valid = spam;
        c1_busy = busy; c1_we = vram_we;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        cyc = 1;
        forever begin
            if (spam) begin
                cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom); cmd_w = 9'($urandom);
                cmd_h = 8'($urandom); cmd_color = 8'($urandom);
            end
            BASE_ADDR = 17'($urandom);
            case (bp_mode)
                0:       vram_wready = 1'b1;
                1:       vram_wready = ((cyc + 1) % 3 == 0);
                default: vram_wready = 1'($urandom_range(0, 1));
            endcase
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                ready_after = cmd_ready; busy_after = busy; done_after = done;
                break;
            end
            if (done === 1'b1) done_cyc = cyc;
            if (vram_we === 1'b1) we_cycles++;
            if (vram_we === 1'b1 && vram_wready) begin
                obs_addr.push_back(vram_waddr); obs_data.push_back(vram_wdata); obs_cyc.push_back(cyc);
            end
            if (prev_stall && (vram_we !== 1'b1 || vram_waddr !== prev_addr || vram_wdata !== prev_data))
                hold_err++;
            prev_stall = (vram_we === 1'b1) && !vram_wready;
            prev_addr = vram_waddr; prev_data = vram_wdata;
            if (busy === 1'b1 && cmd_ready !== 1'b0) ready_busy_err++;
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
            @(posedge clk25); #1;
            cyc++;
        end
        cmd_valid = 1'b0;
        vram_wready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_vram_we got %b want 0", vram_we); end
        checks++; if (vram_waddr !== 17'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", vram_waddr); end
        checks++; if (vram_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got %0d want 0", vram_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(posedge clk25); #1;
        rst_n = 1'b1;
        @(posedge clk25); #1;
        $display("test_reset done");
    endtask

    task automatic test_fill_2x2();
        int bad;
        build_model(10, 5, 2, 2, 0);
        run_cmd(8'd10, 8'd5, 9'd2, 8'd2, 8'hE0, 17'd0, 0, 1'b0, 50);
        checks++; if (timed_out) begin errors++; $display("FAIL fill2x2_timeout got no done want done"); end
        checks++; if (c1_busy !== 1'b1 || c1_we !== 1'b0) begin errors++; $display("FAIL fill2x2_clip_cycle got busy=%b we=%b want busy=1 we=0", c1_busy, c1_we); end
        bad = first_bad(8'hE0);
        checks++; if (bad != -1) begin errors++; $display("FAIL fill2x2_writes got %0d writes (first bad %0d) want %0d", obs_addr.size(), bad, exp_addr.size()); end
        bad = -1;
        foreach (obs_cyc[i]) if (obs_cyc[i] != i + 2 && bad < 0) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL fill2x2_write_cycle write %0d got cycle %0d want %0d", bad, obs_cyc[bad], bad + 2); end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL fill2x2_done_cycle got %0d want 6", done_cyc); end
        checks++; if (ready_after !== 1'b1 || busy_after !== 1'b0 || done_after !== 1'b0) begin errors++; $display("FAIL fill2x2_idle_after got ready=%b busy=%b done=%b want 1 0 0", ready_after, busy_after, done_after); end
        $display("test_fill_2x2 writes=%0d done_cycle=%0d", obs_addr.size(), done_cyc);
    endtask

    task automatic test_corner_clip();
        int bad;
        build_model(250, 190, 20, 10, 0);
        run_cmd(8'd250, 8'd190, 9'd20, 8'd10, 8'h1C, 17'd0, 0, 1'b0, 100);
        checks++; if (obs_addr.size() != 12) begin errors++; $display("FAIL clip_count got %0d want 12", obs_addr.size()); end
        bad = first_bad(8'h1C);
        checks++; if (bad != -1) begin errors++; $display("FAIL clip_writes got first bad index %0d want -1", bad); end
        checks++; if (obs_addr.size() == 0 || obs_addr[0] !== 17'd48890 || obs_addr[obs_addr.size()-1] !== 17'd49151) begin
            errors++; $display("FAIL clip_first_last got %0d..%0d want 48890..49151",
                               (obs_addr.size() != 0) ? obs_addr[0] : 17'd0, (obs_addr.size() != 0) ? obs_addr[obs_addr.size()-1] : 17'd0);
        end
        checks++; if (done_cyc != 14) begin errors++; $display("FAIL clip_done_cycle got %0d want 14", done_cyc); end
        $display("test_corner_clip writes=%0d done_cycle=%0d", obs_addr.size(), done_cyc);
    endtask

    task automatic test_empty();
        logic [8:0] ws[3] = '{9'd0, 9'd5, 9'd5};
        logic [7:0] hs[3] = '{8'd3, 8'd0, 8'd3};
        logic [7:0] ys[3] = '{8'd4, 8'd4, 8'd200};
        for (int k = 0; k < 3; k++) begin
            run_cmd(8'd7, ys[k], ws[k], hs[k], 8'hFF, 17'd100, 0, 1'b0, 20);
            checks++; if (we_cycles != 0) begin errors++; $display("FAIL empty%0d_we got %0d we cycles want 0", k, we_cycles); end
            checks++; if (done_cyc != 2) begin errors++; $display("FAIL empty%0d_done_cycle got %0d want 2", k, done_cyc); end
            checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL empty%0d_ready_cycle3 got %b want 1", k, ready_after); end
            $display("test_empty case=%0d we_cycles=%0d done_cycle=%0d", k, we_cycles, done_cyc);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        build_model(100, 50, 4, 1, 3000);
        run_cmd(8'd100, 8'd50, 9'd4, 8'd1, 8'hA5, 17'd3000, 1, 1'b0, 60);
        checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold got %0d unstable stall cycles want 0", hold_err); end
        bad = first_bad(8'hA5);
        checks++; if (bad != -1) begin errors++; $display("FAIL bp_writes got %0d writes (first bad %0d) want 4", obs_addr.size(), bad); end
        checks++; if (obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1 || done_cyc != 12) begin
            errors++; $display("FAIL bp_done_cycle got %0d want 12", done_cyc);
        end
        $display("test_backpressure writes=%0d done_cycle=%0d", obs_addr.size(), done_cyc);
    endtask

    task automatic test_full_screen();
        int bad;
        build_model(0, 0, 256, 192, 17'h0C000);
        run_cmd(8'd0, 8'd0, 9'd256, 8'd192, 8'h92, 17'h0C000, 0, 1'b1, 49300);
        checks++; if (timed_out) begin errors++; $display("FAIL full_timeout got no done want done"); end
        checks++; if (obs_addr.size() != 49152) begin errors++; $display("FAIL full_count got %0d want 49152", obs_addr.size()); end
        bad = first_bad(8'h92);
        checks++; if (bad != -1) begin errors++; $display("FAIL full_writes got first bad index %0d want -1", bad); end
        checks++; if (obs_addr.size() == 0 || obs_addr[obs_addr.size()-1] !== 17'h17FFF) begin
            errors++; $display("FAIL full_last_addr got %0h want 17fff", (obs_addr.size() != 0) ? obs_addr[obs_addr.size()-1] : 17'd0);
        end
        checks++; if (ready_busy_err != 0) begin errors++; $display("FAIL full_cmd_ready_busy got %0d cycles ready while busy want 0", ready_busy_err); end
        checks++; if (done_cyc != 49154) begin errors++; $display("FAIL full_done_cycle got %0d want 49154", done_cyc); end
        $display("test_full_screen writes=%0d done_cycle=%0d", obs_addr.size(), done_cyc);
    endtask

    task automatic test_reset_mid_fill();
        int  n = 0;
        int  stray = 0;
        bit  hit = 0;
        int  bad;
        vram_wready = 1'b1;
        cmd_x0 = 8'd0; cmd_y0 = 8'd0; cmd_w = 9'd256; cmd_h = 8'd4; cmd_color = 8'h5A; BASE_ADDR = 17'd0;
        cmd_valid = 1'b1;
        @(posedge clk25); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (vram_we === 1'b1 && vram_wready) begin
                n++;
                if (n == 100) begin
                    hit = 1;
                    break;
                end
            end
            @(posedge clk25); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got %0d writes want 100", n); end
        rst_n = 1'b0;
        #1;
        checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we_async got %b want 0", vram_we); end
        repeat (3) @(posedge clk25);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (vram_we !== 1'b0 || done !== 1'b0) stray++;
            @(posedge clk25); #1;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray got %0d cycles with we/done want 0", stray); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got ready=%b busy=%b want 1 0", cmd_ready, busy); end
        build_model(20, 30, 3, 2, 500);
        run_cmd(8'd20, 8'd30, 9'd3, 8'd2, 8'h33, 17'd500, 0, 1'b0, 50);
        bad = first_bad(8'h33);
        checks++; if (bad != -1 || done_cyc != 8) begin errors++; $display("FAIL rst_mid_next_cmd got %0d writes done_cycle %0d want 6 writes done_cycle 8", obs_addr.size(), done_cyc); end
        $display("test_reset_mid_fill aborted_at=%0d next_writes=%0d", n, obs_addr.size());
    endtask

    task automatic test_random();
        logic [7:0]  x0, y0, h, col;
        logic [8:0]  w;
        logic [16:0] base;
        int          bad;
        for (int t = 0; t < 12; t++) begin
            x0   = 8'($urandom);
            y0   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 199)) : 8'($urandom_range(180, 200));
            w    = 9'($urandom_range(0, 40));
            h    = 8'($urandom_range(0, 10));
            col  = 8'($urandom);
            base = 17'($urandom);
            build_model(x0, y0, w, h, base);
            run_cmd(x0, y0, w, h, col, base, 2, 1'b0, 3000);
            bad = first_bad(col);
            checks++; if (timed_out || bad != -1) begin
                errors++; $display("FAIL rand%0d_writes got %0d writes (first bad %0d, timeout %0d) want %0d", t, obs_addr.size(), bad, timed_out, exp_addr.size());
            end
            checks++; if (hold_err != 0) begin errors++; $display("FAIL rand%0d_hold got %0d unstable stall cycles want 0", t, hold_err); end
            checks++; if ((exp_addr.size() == 0 && done_cyc != 2) ||
                          (exp_addr.size() != 0 && (obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1))) begin
                errors++; $display("FAIL rand%0d_done_cycle got %0d want one cycle after last retire", t, done_cyc);
            end
            $display("test_random t=%0d x0=%0d y0=%0d w=%0d h=%0d base=%0h writes=%0d done_cycle=%0d",
                     t, x0, y0, w, h, base, obs_addr.size(), done_cyc);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; vram_wready = 1'b1;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0; BASE_ADDR = '0;
        test_reset();
        test_fill_2x2();
        test_corner_clip();
        test_empty();
        test_backpressure();
        test_full_screen();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Command-driven rectangle fill engine that writes solid RGB332 pixels into the 256x192 framebuffer held in VRAM. It sits directly upstream of the scaled RGB332 scanout stage. It fills the same row-major byte layout, `addr = BASE_ADDR + y*256 + x`, that scanout later reads. It clips each rectangle to the framebuffer, issues one VRAM byte write per pixel under write backpressure, and pulses `done` on completion.

## Interface

Parameters:
- `H_SRC`, 256, framebuffer width in pixels; fixed at 256 because the row stride is `y<<8`.
- `V_SRC`, 192, framebuffer height in lines.
- `ADDR_W`, 17, VRAM address width.

Ports:
- `clk25`  in  1  pixel/system clock; one clock domain only.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine can accept a command (high only in IDLE).
- `cmd_x0`  in  8  left column.
- `cmd_y0`  in  8  top line.
- `cmd_w`  in  9  width, 0..256.
- `cmd_h`  in  8  height, 0..192.
- `cmd_color`  in  8  RGB332 fill value.
- `BASE_ADDR`  in  ADDR_W  framebuffer base; sampled at command accept.
- `vram_we`  out  1  write request.
- `vram_wready`  in  1  VRAM arbiter accepts the write this cycle.
- `vram_waddr`  out  ADDR_W  write address.
- `vram_wdata`  out  8  write byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation

- FSM states: IDLE → CLIP → FILL → DONE → IDLE. When the clipped rectangle is empty, CLIP goes straight to DONE.
- **IDLE:** `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch x0, y0, w, h, color and BASE_ADDR, then go to CLIP.
- **CLIP:** lasts exactly one cycle. `x_end = min(x0+w, 256)`, computed 9-bit unsaturated. `y_end = min(y0+h, 192)`.
  - The rectangle is empty if `w==0`, `h==0` or `y0>=192`. An empty rectangle goes to DONE.
  - Otherwise load `cx=x0`, `cy=y0` and go to FILL.
- **FILL:** `vram_we`=1, `vram_waddr = BASE_ADDR + {cy,8'b0} + cx` (truncated to ADDR_W, wraps mod 2^ADDR_W), `vram_wdata` = color.
  - Raster order: x is the inner loop.
  - A write retires on a cycle with `vram_we && vram_wready`. On retire, `cx++`.
  - When `cx+1 == x_end`: set `cx=x0` and `cy++`.
  - When the last pixel retires (`cx+1==x_end && cy+1==y_end`), go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- While `vram_wready`=0, `vram_we`, `vram_waddr` and `vram_wdata` hold stable.
- Command inputs are ignored while `busy`. BASE_ADDR changes after accept have no effect.
- All outputs are registered.

## Timing

- Reset values (async on `rst_n` low): state IDLE, `cmd_ready`=1, `vram_we`=0, `vram_waddr`=0, `vram_wdata`=0, `busy`=0, `done`=0.
- Take cycle 0 as the accept cycle. Then:
  - Cycle 1 is CLIP: `busy`=1, `vram_we`=0.
  - The first write is presented in cycle 2.
- Non-empty rectangle with N clipped pixels and `vram_wready` held high:
  - Writes occupy cycles 2..N+1.
  - `done` in cycle N+2.
  - `cmd_ready`=1 in cycle N+3.
  - Each cycle with `wready` low adds one cycle.
- Empty rectangle: CLIP in cycle 1, `done` in cycle 2, `cmd_ready` in cycle 3. No `vram_we` at any time.
- Throughput: one pixel per clock maximum.
- Reset mid-FILL:
  - `vram_we` drops immediately and asynchronously.
  - No further writes occur.
  - No `done` pulse is produced for the aborted command.

## Test plan

- **2x2 fill.** BASE=0, x0=10, y0=5, w=2, h=2, color=0xE0, wready=1.
  - Writes to 1290, 1291, 1546, 1547 in cycles 2–5, all with data 0xE0.
  - `done` in cycle 6.
- **Corner clip.** x0=250, w=20, y0=190, h=10.
  - Exactly 12 writes, first addr 48890, last addr 49151.
- **Empty commands.** w=0; then h=0; then y0=200.
  - Each produces no `vram_we` and a `done` pulse in cycle 2.
- **Backpressure.** 4x1 rectangle with `vram_wready` toggling 1,0,0,1,…
  - `vram_waddr` and `vram_wdata` are stable while wready=0.
  - Exactly 4 retired writes, in order.
  - `done` follows the last retire.
- **Full screen plus wrap bound.** BASE=0x0C000, x0=0, y0=0, w=256, h=192.
  - 49152 writes, last addr 0x17FFF.
  - `cmd_valid` asserted during the fill is not accepted (`cmd_ready`=0).
- **Reset mid-fill.** Deassert `rst_n` at the 100th write.
  - `vram_we`=0 immediately.
  - After release, `cmd_ready`=1, `busy`=0, no `done` pulse; the next command runs normally.
